// File: rtl/sp_unit_if.sv
// Stack-pointer unit command/status bundle.
// master: issues commands and observes status; slave: the sp_unit itself.
interface sp_unit_if;
    logic        push;
    logic        pop;
    logic        load;
    logic [13:0] load_val;
    logic        clr_err;
    logic [13:0] sp;
    logic [13:0] sp_dec;
    logic [13:0] depth;
    logic        empty;
    logic        full;
    logic        err;

    modport master (
        output push, pop, load, load_val, clr_err,
        input  sp, sp_dec, depth, empty, full, err
    );

    modport slave (
        input  push, pop, load, load_val, clr_err,
        output sp, sp_dec, depth, empty, full, err
    );
endinterface

// File: rtl/sp_unit.sv
// Downward-growing stack pointer with registered depth/empty/full status.
// Optional macro SP_BOUND_CHECK_EN: push-while-full or pop-while-empty is
// refused, raises a sticky err and parks the unit in HALT until clr_err.
// Without the macro the pointer simply wraps modulo 2^14 and err is 0.
module sp_unit #(
    parameter logic [13:0] SP_INIT  = 14'h3FFF,
    parameter logic [13:0] SP_LIMIT = 14'h2000
) (
    input  logic     clk,
    input  logic     rst_n,
    sp_unit_if.slave bus
);

    logic [13:0] sp_q, sp_d;
    logic [13:0] depth_q, depth_d;
    logic        empty_q, empty_d;
    logic        full_q, full_d;

`ifdef SP_BOUND_CHECK_EN
    typedef enum logic [0:0] {StRun, StHalt} state_e;
    state_e state_q, state_d;
    logic   err_q, err_d;

    // Next SP, error flag and RUN/HALT transition.
    always_comb begin
        sp_d    = sp_q;
        state_d = state_q;
        err_d   = err_q;
        if (bus.load) begin
            sp_d = bus.load_val;
        end else if (state_q == StRun) begin
            if (bus.push && !bus.pop) begin
                if (sp_q == SP_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else begin
                    sp_d = sp_q - 14'd1;
                end
            end else if (bus.pop && !bus.push) begin
                if (sp_q == SP_INIT) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else begin
                    sp_d = sp_q + 14'd1;
                end
            end
        end
        // Load and clr_err in the same HALT cycle both take effect.
        if (state_q == StHalt && bus.clr_err) begin
            state_d = StRun;
            err_d   = 1'b0;
        end
    end

    // FSM state and sticky error register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = bus.clr_err;

    // Next SP: free-running wrap, no bound handling.
    always_comb begin
        sp_d = sp_q;
        if (bus.load) begin
            sp_d = bus.load_val;
        end else if (bus.push && !bus.pop) begin
            sp_d = sp_q - 14'd1;
        end else if (bus.pop && !bus.push) begin
            sp_d = sp_q + 14'd1;
        end
    end

    assign bus.err = 1'b0;
`endif

    // Status derived from the next SP so it lines up with the registered sp.
    always_comb begin
        depth_d = SP_INIT - sp_d;
        empty_d = (sp_d == SP_INIT);
        full_d  = (sp_d == SP_LIMIT);
    end

    // Pointer and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q    <= SP_INIT;
            depth_q <= 14'd0;
            empty_q <= 1'b1;
            full_q  <= (SP_INIT == SP_LIMIT);
        end else begin
            sp_q    <= sp_d;
            depth_q <= depth_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign bus.sp     = sp_q;
    assign bus.sp_dec = sp_q - 14'd1;
    assign bus.depth  = depth_q;
    assign bus.empty  = empty_q;
    assign bus.full   = full_q;

endmodule

// File: tb/tb_sp_unit.sv
// Self-checking bench for sp_unit: directed scenarios plus a randomized run
// compared against a behavioural stack-pointer model.
module tb_sp_unit;

    localparam logic [13:0] Init  = 14'h3FFF;
    localparam logic [13:0] Limit = 14'h3FF0;
`ifdef SP_BOUND_CHECK_EN
    localparam bit Chk = 1'b1;
`else
    localparam bit Chk = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Reference model state.
    logic [13:0] m_sp;
    bit          m_err;
    bit          m_halt;

    sp_unit_if bus ();

    sp_unit #(
        .SP_INIT (Init),
        .SP_LIMIT(Limit)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural effect of one clock edge on the model.
    task automatic model_step(input bit rst, input bit psh, input bit pp, input bit ld,
                              input logic [13:0] lv, input bit clr);
        bit was_halt;
        if (!rst) begin
            m_sp   = Init;
            m_err  = 1'b0;
            m_halt = 1'b0;
            return;
        end
        was_halt = m_halt;
        if (ld) begin
            m_sp = lv;
        end else if (!was_halt) begin
            if (psh && !pp) begin
                if (Chk && m_sp == Limit) begin
                    m_err  = 1'b1;
                    m_halt = 1'b1;
                end else begin
                    m_sp = m_sp - 14'd1;
                end
            end else if (pp && !psh) begin
                if (Chk && m_sp == Init) begin
                    m_err  = 1'b1;
                    m_halt = 1'b1;
                end else begin
                    m_sp = m_sp + 14'd1;
                end
            end
        end
        if (was_halt && clr) begin
            m_halt = 1'b0;
            m_err  = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [13:0] exp_dec;
        logic [13:0] exp_depth;
        exp_dec   = m_sp - 14'd1;
        exp_depth = Init - m_sp;
        check_eq({tag, "_sp"},    32'(bus.sp),     32'(m_sp));
        check_eq({tag, "_dec"},   32'(bus.sp_dec), 32'(exp_dec));
        check_eq({tag, "_depth"}, 32'(bus.depth),  32'(exp_depth));
        check_eq({tag, "_empty"}, 32'(bus.empty),  32'(m_sp == Init));
        check_eq({tag, "_full"},  32'(bus.full),   32'(m_sp == Limit));
        check_eq({tag, "_err"},   32'(bus.err),    32'(m_err));
    endtask

    // Apply one command for one cycle, update the model, compare #1 after the edge.
    task automatic cyc(input string tag, input bit rst, input bit psh, input bit pp,
                       input bit ld, input logic [13:0] lv, input bit clr);
        @(negedge clk);
        rst_n        = rst;
        bus.push     = psh;
        bus.pop      = pp;
        bus.load     = ld;
        bus.load_val = lv;
        bus.clr_err  = clr;
        @(posedge clk);
        model_step(rst, psh, pp, ld, lv, clr);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        cyc("rst", 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0);
    endtask

    task automatic do_push(input string tag);
        cyc(tag, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0, 1'b0);
    endtask

    initial begin
        logic [13:0] lv;
        bit          rst, psh, pp, ld, clr;
        checks       = 0;
        errors       = 0;
        m_sp         = Init;
        m_err        = 1'b0;
        m_halt       = 1'b0;
        rst_n        = 1'b0;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 14'd0;
        bus.clr_err  = 1'b0;

        // Reset state, with commands presented to prove reset dominates.
        cyc("rst_cmd", 1'b0, 1'b1, 1'b0, 1'b1, 14'h1234, 1'b1);
        check_eq("rst_sp", 32'(bus.sp), 32'h3FFF);
        check_eq("rst_empty", 32'(bus.empty), 32'd1);

        // Three pushes.
        for (int i = 0; i < 3; i++) do_push("p3");
        check_eq("p3_sp", 32'(bus.sp), 32'h3FFC);
        check_eq("p3_depth", 32'(bus.depth), 32'd3);
        check_eq("p3_dec", 32'(bus.sp_dec), 32'h3FFB);
        check_eq("p3_empty", 32'(bus.empty), 32'd0);

        // Fill to the limit and push past it.
        do_reset();
        for (int i = 0; i < 15; i++) do_push("fill");
        check_eq("fill_sp", 32'(bus.sp), 32'h3FF0);
        check_eq("fill_full", 32'(bus.full), 32'd1);
        do_push("over");
        do_push("over2");
`ifdef SP_BOUND_CHECK_EN
        check_eq("over_sp", 32'(bus.sp), 32'h3FF0);
        check_eq("over_err", 32'(bus.err), 32'd1);
        cyc("clr", 1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 1'b1);
        check_eq("clr_err", 32'(bus.err), 32'd0);
`else
        check_eq("over_sp", 32'(bus.sp), 32'h3FEE);
        check_eq("over_err", 32'(bus.err), 32'd0);
`endif

        // Pop from empty.
        do_reset();
        cyc("under", 1'b1, 1'b0, 1'b1, 1'b0, 14'd0, 1'b0);
`ifdef SP_BOUND_CHECK_EN
        check_eq("under_sp", 32'(bus.sp), 32'h3FFF);
        check_eq("under_err", 32'(bus.err), 32'd1);
        // HALT: load plus clr_err together.
        do_push("halt_push");
        check_eq("halt_push_sp", 32'(bus.sp), 32'h3FFF);
        cyc("ldclr", 1'b1, 1'b0, 1'b0, 1'b1, 14'h3FFF, 1'b1);
        check_eq("ldclr_err", 32'(bus.err), 32'd0);
        check_eq("ldclr_empty", 32'(bus.empty), 32'd1);
        do_push("run_again");
        check_eq("run_again_sp", 32'(bus.sp), 32'h3FFE);
`else
        check_eq("under_sp", 32'(bus.sp), 32'h0000);
        check_eq("under_depth", 32'(bus.depth), 32'h3FFF);
        check_eq("under_dec", 32'(bus.sp_dec), 32'h3FFF);
`endif

        // Simultaneous push and pop, then load beating push.
        cyc("ld3ffd", 1'b1, 1'b0, 1'b0, 1'b1, 14'h3FFD, 1'b0);
        for (int i = 0; i < 4; i++) cyc("pp", 1'b1, 1'b1, 1'b1, 1'b0, 14'd0, 1'b0);
        check_eq("pp_sp", 32'(bus.sp), 32'h3FFD);
        check_eq("pp_depth", 32'(bus.depth), 32'd2);
        cyc("ldpush", 1'b1, 1'b1, 1'b0, 1'b1, 14'h3000, 1'b0);
        check_eq("ldpush_sp", 32'(bus.sp), 32'h3000);
        check_eq("ldpush_depth", 32'(bus.depth), 32'h0FFF);

        // Idle hold, then reset during a push.
        cyc("idle", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0123, 1'b0);
        cyc("rstpush", 1'b0, 1'b1, 1'b0, 1'b0, 14'd0, 1'b0);
        check_eq("rstpush_sp", 32'(bus.sp), 32'h3FFF);
        check_eq("rstpush_depth", 32'(bus.depth), 32'd0);

        // Randomized run against the model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) >= 2);
            psh = ($urandom_range(0, 99) < 50);
            pp  = ($urandom_range(0, 99) < 45);
            ld  = ($urandom_range(0, 99) < 6);
            clr = ($urandom_range(0, 99) < 15);
            case ($urandom_range(0, 3))
                0:       lv = Init;
                1:       lv = Limit;
                2:       lv = Limit + 14'($urandom_range(0, 15));
                default: lv = 14'($urandom);
            endcase
            // Keep most of the walk inside the legal window.
            if (lv < Limit && $urandom_range(0, 3) != 0) lv = Init;
            cyc("rnd", rst, psh, pp, ld, lv, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sp_unit.md
SP_UNIT -- requirements
Module: sp_unit

Interface
REQ-001 Parameter SP_INIT, default 14'h3FFF: SP value at reset and when the stack is empty; the stack grows downward.
REQ-002 Parameter SP_LIMIT, default 14'h2000: lowest legal SP value (stack full).
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset; synchronous and active-low.
REQ-005 Port push  input  1  decrement SP by one this cycle.
REQ-006 Port pop  input  1  increment SP by one this cycle.
REQ-007 Port load  input  1  overwrite SP with load_val.
REQ-008 Port load_val  input  14  new SP value for load.
REQ-009 Port clr_err  input  1  leave the HALT state.
REQ-010 Port sp  output  14  current stack pointer (registered).
REQ-011 Port sp_dec  output  14  combinational sp-1, modulo 2^14; feeds the address path for push.
REQ-012 Port depth  output  14  registered SP_INIT-sp, modulo 2^14.
REQ-013 Port empty  output  1  registered; high when sp==SP_INIT.
REQ-014 Port full  output  1  registered; high when sp==SP_LIMIT.
REQ-015 Port err  output  1  registered sticky bound-violation flag.

Function
REQ-016 SHALL use 2-state FSM RUN/HALT; reset state RUN.
REQ-017 In RUN, command priority: load > (push&pop) > push > pop; each takes effect at the next rising edge (1-cycle latency).
REQ-018 load: sp<=load_val, depth<=SP_INIT-load_val; no bound check on the loaded value.
REQ-019 push&pop together: sp and depth unchanged (top replaced); never an error.
REQ-020 push alone: sp<=sp-1, depth<=depth+1; all arithmetic is 14-bit, carries and borrows discarded.
REQ-021 pop alone: sp<=sp+1, depth<=depth-1.
REQ-022 empty and full SHALL be computed from the next SP value and registered, so they are valid in the same cycle as sp.
REQ-023 sp_dec SHALL equal sp-1 in every cycle; 14'h0000 yields 14'h3FFF.
REQ-024 In HALT: push and pop are ignored; load is accepted; clr_err moves the FSM to RUN and clears err at the next edge; load and clr_err together apply both.
REQ-025 No command asserted: all registers hold.

Reset
REQ-026 When rst_n=0 at a rising edge: sp=SP_INIT, depth=0, empty=1, full=0, err=0, FSM=RUN; rst_n overrides all other inputs.
REQ-027 Reset asserted mid-operation SHALL discard any command presented in that cycle.

Configuration
REQ-028 Macro SP_BOUND_CHECK_EN defined: in RUN, push while full (without pop) or pop while empty (without push) SHALL leave sp unchanged, set err=1, and enter HALT.
REQ-029 SP_BOUND_CHECK_EN undefined: no HALT state is built; SP wraps modulo 2^14 past either bound; err is constant 0; clr_err is ignored.

Verification
REQ-030 Reset, then 3 push cycles -> sp=14'h3FFC, depth=3, empty=0, sp_dec=14'h3FFB.
REQ-031 SP_LIMIT=14'h3FF0, 15 pushes -> full=1 on the cycle sp=14'h3FF0; a 16th push with SP_BOUND_CHECK_EN -> sp stays 14'h3FF0, err=1; next push ignored; clr_err -> err=0.
REQ-032 From reset, pop -> with macro: sp=14'h3FFF, err=1, HALT; without macro: sp=14'h0000, depth=14'h3FFF, err=0.
REQ-033 sp=14'h3FFD, push&pop together for 4 cycles -> sp stays 14'h3FFD, depth=2; load with load_val=14'h3000 and push together -> sp=14'h3000, depth=14'h0FFF.
REQ-034 In HALT, load with load_val=14'h3FFF plus clr_err -> next cycle sp=14'h3FFF, empty=1, err=0, RUN; rst_n=0 during a push -> sp=14'h3FFF, depth=0.
